// File: rtl/pattern_apply_check.sv
// pattern_apply_check
// Clocked pattern applicator/comparator for a combinational DUT. It accepts one
// stored ATPG pattern (stimulus, expected response, compare mask, last flag),
// drives the stimulus, waits CAPTURE_DELAY cycles, then strobes the DUT outputs.
// Each strobe compares the outputs under the per-bit mask, updates the strobe
// index and a saturating failing-bit counter, and records the first failing
// pattern. After the pattern flagged last, the block parks in DONE until reset.
`timescale 1ns/1ps

module pattern_apply_check #(
  parameter int NINPUTS       = 5,
  parameter int NOUTPUTS      = 2,
  parameter int CAPTURE_DELAY = 2,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  // pattern source
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [NINPUTS-1:0]  pat_pi,
  input  logic [NOUTPUTS-1:0] pat_xpct,
  input  logic [NOUTPUTS-1:0] pat_mask,
  input  logic                pat_last,
  // DUT side
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  // status and results
  output logic                busy,
  output logic                done,
  output logic                mismatch,
  output logic [NOUTPUTS-1:0] mismatch_bits,
  output logic [CNT_W-1:0]    pattern_idx,
  output logic [CNT_W-1:0]    fail_count,
  output logic                first_fail_valid,
  output logic [CNT_W-1:0]    first_fail_idx
);

  // Delay counter only has to hold CAPTURE_DELAY down to 1.
  localparam int DLY_W = (CAPTURE_DELAY < 2) ? 1 : $clog2(CAPTURE_DELAY + 1);
  // Popcount of one strobe can reach NOUTPUTS.
  localparam int POP_W = (NOUTPUTS < 2) ? 1 : $clog2(NOUTPUTS + 1);
  // One spare bit above the wider operand so the sum never wraps before the
  // saturation test sees it.
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [DLY_W-1:0]    cnt_reg, cnt_next;

  // Pattern fields held for the duration of one pattern.
  logic [NINPUTS-1:0]  dut_pi_reg;
  logic [NOUTPUTS-1:0] xpct_reg;
  logic [NOUTPUTS-1:0] mask_reg;
  logic                last_reg;

  // Persistent results.
  logic                mismatch_reg;
  logic [NOUTPUTS-1:0] mismatch_bits_reg;
  logic [CNT_W-1:0]    pattern_idx_reg;
  logic [CNT_W-1:0]    fail_count_reg;
  logic                first_fail_valid_reg;
  logic [CNT_W-1:0]    first_fail_idx_reg;

  // Per-strobe compare results.
  logic                accept;
  logic                strobe;
  logic [NOUTPUTS-1:0] mm;
  logic                mm_any;
  logic [POP_W-1:0]    mm_pop;
  logic [SUM_W-1:0]    fail_sum;
  logic [CNT_W-1:0]    fail_sat;

  // Handshake depends on state only, so an upstream source never sees a
  // combinational path from its own valid back to ready.
  assign pat_ready = (state_reg == IDLE);
  assign accept    = pat_valid && pat_ready;
  assign strobe    = (state_reg == STROBE);
  assign busy      = (state_reg == APPLY) || (state_reg == STROBE);
  assign done      = (state_reg == DONE);

  // Masked compare, one bit per DUT output.
  for (genvar gi = 0; gi < NOUTPUTS; gi++) begin : g_cmp
    assign mm[gi] = (dut_po[gi] ^ xpct_reg[gi]) & mask_reg[gi];
  end

  assign mm_any = |mm;

  // Count failing bits of the current strobe and saturate the running total.
  always_comb begin
    mm_pop = '0;
    for (int i = 0; i < NOUTPUTS; i++) begin
      mm_pop = mm_pop + POP_W'(mm[i]);
    end
    fail_sum = SUM_W'(fail_count_reg) + SUM_W'(mm_pop);
    if (fail_sum > SUM_W'({CNT_W{1'b1}})) begin
      fail_sat = {CNT_W{1'b1}};
    end else begin
      fail_sat = fail_sum[CNT_W-1:0];
    end
  end

  // Next-state logic: APPLY runs CAPTURE_DELAY cycles, STROBE exactly one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = DLY_W'(CAPTURE_DELAY);
          state_next = APPLY;
        end
      end
      APPLY: begin
        if (cnt_reg == DLY_W'(1)) begin
          state_next = STROBE;
        end else begin
          cnt_next = cnt_reg - DLY_W'(1);
        end
      end
      STROBE: begin
        state_next = last_reg ? DONE : IDLE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and delay counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Pattern capture on accept; DUT drive stays on the last pattern in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_pi_reg <= '0;
      xpct_reg   <= '0;
      mask_reg   <= '0;
      last_reg   <= 1'b0;
    end else if (accept) begin
      dut_pi_reg <= pat_pi;
      xpct_reg   <= pat_xpct;
      mask_reg   <= pat_mask;
      last_reg   <= pat_last;
    end
  end

  // Result update at the closing edge of the strobe cycle; mismatch self-clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_reg         <= 1'b0;
      mismatch_bits_reg    <= '0;
      pattern_idx_reg      <= '0;
      fail_count_reg       <= '0;
      first_fail_valid_reg <= 1'b0;
      first_fail_idx_reg   <= '0;
    end else begin
      mismatch_reg <= 1'b0;
      if (strobe) begin
        mismatch_reg      <= mm_any;
        mismatch_bits_reg <= mm;
        fail_count_reg    <= fail_sat;
        pattern_idx_reg   <= pattern_idx_reg + CNT_W'(1);
        if (mm_any && !first_fail_valid_reg) begin
          first_fail_valid_reg <= 1'b1;
          first_fail_idx_reg   <= pattern_idx_reg;
        end
      end
    end
  end

  assign dut_pi           = dut_pi_reg;
  assign mismatch         = mismatch_reg;
  assign mismatch_bits    = mismatch_bits_reg;
  assign pattern_idx      = pattern_idx_reg;
  assign fail_count       = fail_count_reg;
  assign first_fail_valid = first_fail_valid_reg;
  assign first_fail_idx   = first_fail_idx_reg;

endmodule

// File: tb/tb_pattern_apply_check.sv
// tb_pattern_apply_check
// Directed bench: instance a uses default parameters, instance b uses CNT_W=2
// for the saturation/wrap case. Inputs are shared except pat_valid.
`timescale 1ns/1ps

module tb_pattern_apply_check;

  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic [4:0] pat_pi = '0;
  logic [1:0] pat_xpct = '0;
  logic [1:0] pat_mask = '0;
  logic       pat_last = 1'b0;
  logic [1:0] dut_po = '0;

  logic        ready_a, busy_a, done_a, mm_a, ffv_a;
  logic [4:0]  dut_pi_a;
  logic [1:0]  mmb_a;
  logic [15:0] idx_a, fc_a, ffi_a;

  logic        ready_b, busy_b, done_b, mm_b, ffv_b;
  logic [4:0]  dut_pi_b;
  logic [1:0]  mmb_b;
  logic [1:0]  idx_b, fc_b, ffi_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_apply_check #(.NINPUTS(5), .NOUTPUTS(2), .CAPTURE_DELAY(CD), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .pat_valid(valid_a), .pat_ready(ready_a),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .dut_pi(dut_pi_a), .dut_po(dut_po),
    .busy(busy_a), .done(done_a), .mismatch(mm_a), .mismatch_bits(mmb_a),
    .pattern_idx(idx_a), .fail_count(fc_a),
    .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
  );

  pattern_apply_check #(.NINPUTS(5), .NOUTPUTS(2), .CAPTURE_DELAY(CD), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .pat_valid(valid_b), .pat_ready(ready_b),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .dut_pi(dut_pi_b), .dut_po(dut_po),
    .busy(busy_b), .done(done_b), .mismatch(mm_b), .mismatch_bits(mmb_b),
    .pattern_idx(idx_b), .fail_count(fc_b),
    .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pattern to instance a (b=0) or b (b=1), check the drive one
  // cycle after accept, and return #1 after the strobe's closing edge.
  task automatic send(input bit b, input logic [4:0] pi, input logic [1:0] x,
                      input logic [1:0] m, input bit l, input logic [1:0] po);
    chk("ready_before_send", b ? ready_b : ready_a, 1);
    pat_pi = pi; pat_xpct = x; pat_mask = m; pat_last = l; dut_po = po;
    if (b) valid_b = 1'b1; else valid_a = 1'b1;
    tick(1);
    valid_a = 1'b0; valid_b = 1'b0;
    chk("dut_pi_after_accept", b ? dut_pi_b : dut_pi_a, pi);
    tick(CD + 1);
    $display("pattern inst=%0d pi=%b xpct=%b mask=%b po=%b last=%0d", b, pi, x, m, po, l);
  endtask

  initial begin
    // Reset / idle defaults
    tick(2);
    rst = 1'b0;
    chk("rst_dut_pi", dut_pi_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_mismatch", mm_a, 0);
    chk("rst_mismatch_bits", mmb_a, 0);
    chk("rst_pattern_idx", idx_a, 0);
    chk("rst_fail_count", fc_a, 0);
    chk("rst_ffv", ffv_a, 0);
    chk("rst_ffi", ffi_a, 0);
    chk("rst_ready", ready_a, 1);

    // Single passing pattern, last
    send(0, 5'b11101, 2'b10, 2'b11, 1'b1, 2'b10);
    chk("pass_idx", idx_a, 1);
    chk("pass_fc", fc_a, 0);
    chk("pass_mm", mm_a, 0);
    chk("pass_done", done_a, 1);
    chk("pass_ready", ready_a, 0);
    chk("pass_busy", busy_a, 0);
    tick(2);
    chk("pass_mm_later", mm_a, 0);
    chk("pass_done_held", done_a, 1);
    chk("pass_dut_pi_held", dut_pi_a, 5'b11101);

    // Fail capture
    rst = 1'b1; tick(1); rst = 1'b0;
    send(0, 5'b00001, 2'b10, 2'b11, 1'b0, 2'b10);
    chk("p0_idx", idx_a, 1);
    chk("p0_ffv", ffv_a, 0);
    send(0, 5'b00010, 2'b00, 2'b11, 1'b0, 2'b11);
    chk("p1_mm", mm_a, 1);
    chk("p1_mmb", mmb_a, 2'b11);
    chk("p1_fc", fc_a, 2);
    chk("p1_ffv", ffv_a, 1);
    chk("p1_ffi", ffi_a, 1);
    chk("p1_idx", idx_a, 2);
    tick(1);
    chk("p1_mm_pulse_end", mm_a, 0);
    chk("p1_mmb_hold", mmb_a, 2'b11);
    send(0, 5'b00011, 2'b00, 2'b01, 1'b0, 2'b11);
    chk("p2_mmb", mmb_a, 2'b01);
    chk("p2_fc", fc_a, 3);
    chk("p2_ffi_kept", ffi_a, 1);

    // Masking
    send(0, 5'b00100, 2'b01, 2'b01, 1'b0, 2'b11);
    chk("mask_lo_mm", mm_a, 0);
    chk("mask_lo_mmb", mmb_a, 0);
    chk("mask_lo_fc", fc_a, 3);
    send(0, 5'b00101, 2'b00, 2'b00, 1'b0, 2'b11);
    chk("mask_none_mm", mm_a, 0);
    chk("mask_none_fc", fc_a, 3);
    send(0, 5'b00100, 2'b01, 2'b11, 1'b1, 2'b11);
    chk("mask_all_mmb", mmb_a, 2'b10);
    chk("mask_all_fc", fc_a, 4);
    chk("mask_all_idx", idx_a, 6);
    chk("mask_all_done", done_a, 1);

    // Saturation and index wrap with CNT_W = 2
    rst = 1'b1; tick(1); rst = 1'b0;
    send(1, 5'b01000, 2'b00, 2'b11, 1'b0, 2'b11);
    chk("sat1_fc", fc_b, 2);
    send(1, 5'b01001, 2'b00, 2'b11, 1'b0, 2'b11);
    chk("sat2_fc", fc_b, 3);
    send(1, 5'b01010, 2'b00, 2'b11, 1'b0, 2'b11);
    chk("sat3_fc", fc_b, 3);
    chk("sat3_idx", idx_b, 3);
    send(1, 5'b01011, 2'b11, 2'b11, 1'b0, 2'b11);
    chk("wrap_idx", idx_b, 0);
    chk("wrap_fc", fc_b, 3);
    chk("wrap_ffi", ffi_b, 0);
    chk("wrap_ffv", ffv_b, 1);

    // Reset mid-APPLY with pat_valid held
    rst = 1'b1; tick(1); rst = 1'b0;
    pat_pi = 5'b10101; pat_xpct = 2'b00; pat_mask = 2'b11; pat_last = 1'b0; dut_po = 2'b11;
    valid_a = 1'b1;
    tick(1);
    chk("mid_busy", busy_a, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_dut_pi", dut_pi_a, 0);
    chk("mid_rst_idx", idx_a, 0);
    chk("mid_rst_mm", mm_a, 0);
    chk("mid_rst_ready", ready_a, 1);
    rst = 1'b0;
    tick(1);
    chk("reaccept_dut_pi", dut_pi_a, 5'b10101);
    chk("reaccept_busy", busy_a, 1);
    valid_a = 1'b0;
    tick(CD + 1);
    chk("reaccept_idx", idx_a, 1);
    chk("reaccept_mm", mm_a, 1);
    chk("reaccept_fc", fc_a, 2);
    chk("reaccept_ffi", ffi_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
